// File: rtl/gng_lzd_pkg.sv
// gng_lzd_pkg: shared widths and payload types for the normalisation-stage LZD scheduler
package gng_lzd_pkg;
    localparam int LZD_W = 61;
    localparam int LZD_LAT = 2;

    typedef struct packed {
        logic [5:0] pos;
        logic [6:0] cnt;
    } lzd_rsp_t;

    typedef struct packed {
        logic valid;
        logic id;
    } lzd_tag_t;
endpackage

// File: rtl/lzd_rsp_fifo.sv
// lzd_rsp_fifo: first-word-fall-through response FIFO; the head reads as zero while empty
module lzd_rsp_fifo
    import gng_lzd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  lzd_rsp_t din,
    input  logic     pop,
    output logic     valid,
    output lzd_rsp_t dout
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    lzd_rsp_t      mem_q [DEPTH];
    lzd_rsp_t      mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_pop;

    always_comb begin
        valid = cnt_q != '0;
        dout = valid ? mem_q[rd_q] : '0;
        do_pop = pop && valid;
        mem_d = mem_q;
        if (push) mem_d[wr_q] = din;
        wr_d = push ? ((wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1) : wr_q;
        rd_d = do_pop ? ((rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1) : rd_q;
        cnt_d = cnt_q + CW'(push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Upstream credits must make a push into a full FIFO impossible
    assert property (@(posedge clk) disable iff (!rst) !(push && cnt_q == CW'(DEPTH)));
endmodule

// File: rtl/lzd_arbiter.sv
// lzd_arbiter: round-robin, credit-gated sharing of one fixed-latency LZD between two requesters
module lzd_arbiter
    import gng_lzd_pkg::*;
#(
    parameter int W = LZD_W,
    parameter int LAT = LZD_LAT,
    parameter int DEPTH = LAT + 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_data,
    output logic         req1_ready,
    output logic [W-1:0] lzd_in,
    input  logic [5:0]   lzd_pos,
    input  logic [6:0]   lzd_cnt,
    output logic         rsp0_valid,
    output logic [5:0]   rsp0_pos,
    output logic [6:0]   rsp0_cnt,
    input  logic         rsp0_ready,
    output logic         rsp1_valid,
    output logic [5:0]   rsp1_pos,
    output logic [6:0]   rsp1_cnt,
    input  logic         rsp1_ready
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] credit0_q, credit0_d, credit1_q, credit1_d;
    logic          last_q, last_d;
    logic          issue_v_q, issue_v_d, issue_id_q, issue_id_d;
    logic [W-1:0]  lzd_in_q, lzd_in_d;
    lzd_tag_t      tag_q [LAT];
    lzd_tag_t      tag_d [LAT];
    logic          elig0, elig1, gnt0, gnt1, pop0, pop1, push0, push1;
    lzd_rsp_t      rsp_in, rsp0, rsp1;

    always_comb begin
        elig0 = rst && req0_valid && credit0_q != '0;
        elig1 = rst && req1_valid && credit1_q != '0;
        gnt0 = elig0 && (!elig1 || last_q);
        gnt1 = elig1 && (!elig0 || !last_q);
        pop0 = rsp0_valid && rsp0_ready;
        pop1 = rsp1_valid && rsp1_ready;
        credit0_d = credit0_q + CW'(pop0) - CW'(gnt0);
        credit1_d = credit1_q + CW'(pop1) - CW'(gnt1);
        last_d = (gnt0 || gnt1) ? gnt1 : last_q;
        issue_v_d = gnt0 || gnt1;
        issue_id_d = gnt1;
        lzd_in_d = gnt0 ? req0_data : (gnt1 ? req1_data : lzd_in_q);
        // The tag follows the operand from the cycle it sits on lzd_in
        tag_d[0] = {issue_v_q, issue_id_q};
        for (int i = 1; i < LAT; i++) tag_d[i] = tag_q[i-1];
        push0 = tag_q[LAT-1].valid && !tag_q[LAT-1].id;
        push1 = tag_q[LAT-1].valid && tag_q[LAT-1].id;
        rsp_in = {lzd_pos, lzd_cnt};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            credit0_q <= CW'(DEPTH);
            credit1_q <= CW'(DEPTH);
            last_q <= 1'b1;
            issue_v_q <= 1'b0;
            issue_id_q <= 1'b0;
            lzd_in_q <= '0;
            tag_q <= '{default: '0};
        end else begin
            credit0_q <= credit0_d;
            credit1_q <= credit1_d;
            last_q <= last_d;
            issue_v_q <= issue_v_d;
            issue_id_q <= issue_id_d;
            lzd_in_q <= lzd_in_d;
            tag_q <= tag_d;
        end
    end

    lzd_rsp_fifo #(.DEPTH(DEPTH)) u_fifo0 (
        .clk(clk), .rst(rst), .push(push0), .din(rsp_in),
        .pop(rsp0_ready), .valid(rsp0_valid), .dout(rsp0)
    );

    lzd_rsp_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .clk(clk), .rst(rst), .push(push1), .din(rsp_in),
        .pop(rsp1_ready), .valid(rsp1_valid), .dout(rsp1)
    );

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign lzd_in = lzd_in_q;
    assign rsp0_pos = rsp0.pos;
    assign rsp0_cnt = rsp0.cnt;
    assign rsp1_pos = rsp1.pos;
    assign rsp1_cnt = rsp1.cnt;
endmodule

// File: tb/tb_lzd_arbiter.sv
// tb_lzd_arbiter: directed scenarios against a two-cycle LZD stub
module tb_lzd_arbiter;
    logic        clk, rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [60:0] req0_data, req1_data, lzd_in;
    logic [5:0]  lzd_pos, rsp0_pos, rsp1_pos, s1, s2;
    logic [6:0]  lzd_cnt, rsp0_cnt, rsp1_cnt;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    int          n_err, n_chk;

    lzd_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .lzd_in(lzd_in), .lzd_pos(lzd_pos), .lzd_cnt(lzd_cnt),
        .rsp0_valid(rsp0_valid), .rsp0_pos(rsp0_pos), .rsp0_cnt(rsp0_cnt), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_pos(rsp1_pos), .rsp1_cnt(rsp1_cnt), .rsp1_ready(rsp1_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] lzc(input logic [60:0] v);
        logic [5:0] r;
        logic       f;
        r = 6'd61;
        f = 1'b0;
        for (int i = 60; i >= 0; i--) begin
            if (!f && v[i]) begin
                r = 6'(60 - i);
                f = 1'b1;
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        s1 <= lzc(lzd_in);
        s2 <= s1;
    end
    assign lzd_pos = s2;
    assign lzd_cnt = {1'b0, s2};

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data = '0;
        req1_data = '0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data = 61'h1;
        req1_data = 61'h1;
        #1;
        n_chk++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
        end
        @(negedge clk);
        #1;
        n_chk++;
        if (lzd_in !== 61'h0) begin
            n_err++;
            $display("FAIL reset_lzd_in: got %h want 0", lzd_in);
        end
        n_chk++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rsp_valid: got %b%b want 00", rsp0_valid, rsp1_valid);
        end
        n_chk++;
        if (rsp0_pos !== 6'd0 || rsp0_cnt !== 7'd0 || rsp1_pos !== 6'd0 || rsp1_cnt !== 7'd0) begin
            n_err++;
            $display("FAIL reset_rsp_data: got %0d %0d %0d %0d want 0 0 0 0", rsp0_pos, rsp0_cnt, rsp1_pos, rsp1_cnt);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_single();
        logic [60:0] d;
        d = 61'h0400_0000_0000_0000;
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1;
        req0_data = d;
        #1;
        n_chk++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL single_grant: got %b%b want 10", req0_ready, req1_ready);
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            req0_valid = 1'b0;
            #1;
            if (k == 1) begin
                n_chk++;
                if (lzd_in !== d) begin
                    n_err++;
                    $display("FAIL single_lzd_in: got %h want %h", lzd_in, d);
                end
            end
            n_chk++;
            if (rsp0_valid !== (k == 4) || rsp1_valid !== 1'b0) begin
                n_err++;
                $display("FAIL single_rsp_valid k=%0d: got %b%b want %b0", k, rsp0_valid, rsp1_valid, k == 4);
            end
            if (k == 4) begin
                n_chk++;
                if (rsp0_pos !== 6'd2 || rsp0_cnt !== 7'd2) begin
                    n_err++;
                    $display("FAIL single_rsp_data: got %0d %0d want 2 2", rsp0_pos, rsp0_cnt);
                end
            end
        end
    endtask

    task automatic test_contention();
        logic [60:0] d0 [3];
        logic [60:0] d1 [3];
        logic [5:0]  e0 [3];
        logic [5:0]  e1 [3];
        d0 = '{61'h1000_0000_0000_0000, 61'h1, 61'h10_0000_0000};
        d1 = '{61'h0800_0000_0000_0000, 61'h1_0000, 61'hFF};
        e0 = '{6'd0, 6'd60, 6'd24};
        e1 = '{6'd1, 6'd44, 6'd53};
        do_reset();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            req0_valid = k < 6;
            req1_valid = k < 6;
            if (k < 6) begin
                req0_data = d0[k/2];
                req1_data = d1[k/2];
            end
            #1;
            if (k < 6) begin
                n_chk++;
                if (req0_ready !== (k % 2 == 0) || req1_ready !== (k % 2 == 1)) begin
                    n_err++;
                    $display("FAIL contention_grant k=%0d: got %b%b want %b%b", k, req0_ready, req1_ready, k % 2 == 0, k % 2 == 1);
                end
            end
            n_chk++;
            if (rsp0_valid !== (k == 4 || k == 6 || k == 8) || rsp1_valid !== (k == 5 || k == 7 || k == 9)) begin
                n_err++;
                $display("FAIL contention_rsp_valid k=%0d: got %b%b", k, rsp0_valid, rsp1_valid);
            end
            if (k == 4 || k == 6 || k == 8) begin
                n_chk++;
                if (rsp0_pos !== e0[(k-4)/2] || rsp0_cnt !== {1'b0, e0[(k-4)/2]}) begin
                    n_err++;
                    $display("FAIL contention_rsp0 k=%0d: got %0d %0d want %0d", k, rsp0_pos, rsp0_cnt, e0[(k-4)/2]);
                end
            end
            if (k == 5 || k == 7 || k == 9) begin
                n_chk++;
                if (rsp1_pos !== e1[(k-5)/2] || rsp1_cnt !== {1'b0, e1[(k-5)/2]}) begin
                    n_err++;
                    $display("FAIL contention_rsp1 k=%0d: got %0d %0d want %0d", k, rsp1_pos, rsp1_cnt, e1[(k-5)/2]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [10:0] p0, p1;
        int          acc;
        p0 = 11'h055;
        p1 = 11'h7AA;
        acc = 0;
        do_reset();
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            rsp0_ready = 1'b0;
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            req0_data = 61'h1;
            req1_data = 61'h2;
            #1;
            n_chk++;
            if (req0_ready !== p0[k] || req1_ready !== p1[k]) begin
                n_err++;
                $display("FAIL backpressure_grant k=%0d: got %b%b want %b%b", k, req0_ready, req1_ready, p0[k], p1[k]);
            end
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            req1_valid = 1'b0;
        end
        #1;
        n_chk++;
        if (req0_ready !== 1'b0 || rsp0_valid !== 1'b1) begin
            n_err++;
            $display("FAIL backpressure_stall: got ready=%b rsp_valid=%b want 0 1", req0_ready, rsp0_valid);
        end
        @(negedge clk);
        rsp0_ready = 1'b1;
        #1;
        n_chk++;
        if (rsp0_pos !== 6'd60 || rsp0_cnt !== 7'd60) begin
            n_err++;
            $display("FAIL backpressure_head: got %0d %0d want 60 60", rsp0_pos, rsp0_cnt);
        end
        if (req0_ready === 1'b1) acc++;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            rsp0_ready = 1'b0;
            #1;
            if (req0_ready === 1'b1) acc++;
        end
        n_chk++;
        if (acc != 1) begin
            n_err++;
            $display("FAIL backpressure_one_more: got %0d accepts want 1", acc);
        end
        req0_valid = 1'b0;
    endtask

    task automatic test_reset_midflight();
        int acc;
        acc = 0;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            req0_valid = (k < 2) || (k == 3);
            req1_valid = k < 2;
            req0_data = 61'h1;
            req1_data = 61'h1;
            rst = (k != 3);
            #1;
            if (k < 2) begin
                n_chk++;
                if (req0_ready !== (k == 0) || req1_ready !== (k == 1)) begin
                    n_err++;
                    $display("FAIL midflight_grant k=%0d: got %b%b", k, req0_ready, req1_ready);
                end
            end
            if (k == 3) begin
                n_chk++;
                if (req0_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL midflight_ready_in_reset: got %b want 0", req0_ready);
                end
            end
            if (k >= 4) begin
                n_chk++;
                if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL midflight_discard k=%0d: got %b%b want 00", k, rsp0_valid, rsp1_valid);
                end
            end
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            rsp0_ready = 1'b0;
            req0_valid = 1'b1;
            #1;
            if (k == 0) begin
                n_chk++;
                if (req0_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL midflight_ready_return: got %b want 1", req0_ready);
                end
            end
            if (req0_ready === 1'b1) acc++;
        end
        n_chk++;
        if (acc != 4) begin
            n_err++;
            $display("FAIL midflight_credits: got %0d accepts want 4", acc);
        end
        req0_valid = 1'b0;
    endtask

    task automatic test_zero();
        do_reset();
        @(negedge clk);
        req1_valid = 1'b1;
        req1_data = '0;
        #1;
        n_chk++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            n_err++;
            $display("FAIL zero_grant: got %b%b want 01", req0_ready, req1_ready);
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            req1_valid = 1'b0;
            #1;
            n_chk++;
            if (rsp1_valid !== (k == 4) || rsp0_valid !== 1'b0) begin
                n_err++;
                $display("FAIL zero_rsp_valid k=%0d: got %b%b want 0%b", k, rsp0_valid, rsp1_valid, k == 4);
            end
            if (k == 4) begin
                n_chk++;
                if (rsp1_pos !== 6'd61 || rsp1_cnt !== 7'd61) begin
                    n_err++;
                    $display("FAIL zero_rsp_data: got %0d %0d want 61 61", rsp1_pos, rsp1_cnt);
                end
            end
        end
    endtask

    initial begin
        n_err = 0;
        n_chk = 0;
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data = '0;
        req1_data = '0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_reset_midflight();
        test_zero();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
